// File: rtl/axil_adder_regs.sv
// axil_adder_regs
// AXI4-Lite responder register block for the adder peripheral.
//   reg0-reg3 : RW operand/scratch registers (reg0/reg1 also drive op_a/op_b)
//   reg4      : SUM of reg0+reg1, registered (RO)
//   reg5      : {31'b0, carry} (RO)
//   reg6      : WRCNT, count of OKAY write commits (RO)
//   reg7      : ID_VALUE (RO)
// Optional feature macro: AXIL_ADDER_SAT_EN (SUM saturates on carry).
// Ports:
//   clock, reset           single clock, synchronous active-high reset
//   s_axi_aw* / s_axi_w*    write address / data channels (one-entry buffer each)
//   s_axi_b*                write response channel
//   s_axi_ar* / s_axi_r*    read address / data channels
//   op_a, op_b              live copies of reg0, reg1
module axil_adder_regs #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] ID_VALUE           = 32'hADD0_0001
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   op_a,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   op_b
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam logic [DW-1:0] ONE = 1;

    logic          aw_full;
    logic [2:0]    aw_idx;
    logic          w_full;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;
    logic [DW-1:0] regs [4];
    logic [DW-1:0] sum_q;
    logic          carry_q;
    logic [DW-1:0] wrcnt;
    logic [DW-1:0] rd_mux;
    logic [DW:0]   sum_full;
    logic          commit;
    logic          unused_ok;

    assign unused_ok = &{1'b0, s_axi_awprot, s_axi_arprot,
                         s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign s_axi_awready = !aw_full;
    assign s_axi_wready  = !w_full;
    assign s_axi_arready = !s_axi_rvalid;
    assign s_axi_rresp   = 2'b00;
    assign op_a          = regs[0];
    assign op_b          = regs[1];

    // A commit needs both halves buffered and the previous response retired.
    assign commit   = aw_full && w_full && !s_axi_bvalid;
    assign sum_full = {1'b0, regs[0]} + {1'b0, regs[1]};

    // Write path: independent AW/W buffers, commit, B response.
    always_ff @(posedge clock) begin
        if (reset) begin
            aw_full      <= 1'b0;
            aw_idx       <= '0;
            w_full       <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
            wrcnt        <= '0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (s_axi_awvalid && !aw_full) begin
                aw_full <= 1'b1;
                aw_idx  <= s_axi_awaddr[4:2];
            end
            if (s_axi_wvalid && !w_full) begin
                w_full   <= 1'b1;
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
            if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
            // commit requires !bvalid, so it never collides with the B handshake
            // above; it requires both buffers full, so it never collides with
            // the buffer loads either.
            if (commit) begin
                aw_full      <= 1'b0;
                w_full       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                if (!aw_idx[2]) begin
                    for (int b = 0; b < SW; b++) begin
                        if (w_strb_q[b]) begin
                            regs[aw_idx[1:0]][8*b +: 8] <= w_data_q[8*b +: 8];
                        end
                    end
                    wrcnt       <= wrcnt + ONE;
                    s_axi_bresp <= 2'b00;
                end else begin
                    s_axi_bresp <= 2'b10;
                end
            end
        end
    end

    // Sum follows the operands with one cycle of latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            carry_q <= sum_full[DW];
`ifdef AXIL_ADDER_SAT_EN
            sum_q   <= sum_full[DW] ? '1 : sum_full[DW-1:0];
`else
            sum_q   <= sum_full[DW-1:0];
`endif
        end
    end

    always_comb begin
        rd_mux = '0;
        case (s_axi_araddr[4:2])
            3'd0:    rd_mux = regs[0];
            3'd1:    rd_mux = regs[1];
            3'd2:    rd_mux = regs[2];
            3'd3:    rd_mux = regs[3];
            3'd4:    rd_mux = sum_q;
            3'd5:    rd_mux = {{(DW-1){1'b0}}, carry_q};
            3'd6:    rd_mux = wrcnt;
            default: rd_mux = ID_VALUE;
        endcase
    end

    // Read path: rdata is captured on the AR handshake edge, so a commit on
    // the same edge is not yet visible to this read.
    always_ff @(posedge clock) begin
        if (reset) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
        end else if (s_axi_arvalid && !s_axi_rvalid) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_mux;
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_adder_regs.sv
// Testbench for axil_adder_regs: directed AXI-Lite transactions checked
// against a register-map model, plus a per-cycle operand output check.
module tb_axil_adder_regs;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  s_axi_awaddr = '0;
    logic [2:0]  s_axi_awprot = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [4:0]  s_axi_araddr = '0;
    logic [2:0]  s_axi_arprot = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic [31:0] op_a;
    logic [31:0] op_b;

    localparam logic [31:0] ID = 32'hADD0_0001;

    axil_adder_regs dut (
        .clock(clock), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .op_a(op_a), .op_b(op_b)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_reg [4];
    logic [31:0] m_wrcnt;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [32:0] s;
        s = {1'b0, m_reg[0]} + {1'b0, m_reg[1]};
        case (a[4:2])
            3'd0, 3'd1, 3'd2, 3'd3: return m_reg[a[3:2]];
`ifdef AXIL_ADDER_SAT_EN
            3'd4: return s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
            3'd4: return s[31:0];
`endif
            3'd5: return {31'b0, s[32]};
            3'd6: return m_wrcnt;
            default: return ID;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_wrcnt = '0;
    endtask

    task automatic model_write(input logic [4:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [1:0] resp);
        if (a[4]) begin
            resp = 2'b10;
        end else begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_reg[a[3:2]][8*b +: 8] = d[8*b +: 8];
            m_wrcnt = m_wrcnt + 32'd1;
            resp = 2'b00;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Operands must track the model whenever no write response is pending.
    always @(posedge clock) begin
        #2;
        if (chk_en && !reset && !s_axi_bvalid) begin
            check("op_a", op_a, m_reg[0]);
            check("op_b", op_b, m_reg[1]);
        end
    end

    task automatic do_aw_w(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int lead);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0;
        @(posedge clock); #1;
        s_axi_wvalid = 1'b1; s_axi_wdata = d; s_axi_wstrb = s; s_axi_awaddr = a;
        if (lead == 0) s_axi_awvalid = 1'b1;
        while (!(aw_done && w_done) && cyc < 60) begin
            @(negedge clock);
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            @(posedge clock); #1;
            cyc++;
            if (aw_hs) begin s_axi_awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin s_axi_wvalid = 1'b0;  w_done = 1;  end
            if (!aw_done && !s_axi_awvalid && cyc >= lead) s_axi_awvalid = 1'b1;
        end
        if (!(aw_done && w_done)) fail_timeout("aw_w_handshake");
    endtask

    task automatic wait_bvalid();
        int n;
        n = 0;
        do begin @(negedge clock); n++; end while (!s_axi_bvalid && n < 50);
        if (!s_axi_bvalid) fail_timeout("bvalid");
    endtask

    task automatic b_accept();
        s_axi_bready = 1'b1;
        @(posedge clock); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] got);
        logic [1:0] exp;
        do_aw_w(a, d, s, 0);
        wait_bvalid();
        model_write(a, d, s, exp);
        got = s_axi_bresp;
        check($sformatf("bresp_%h", a), 32'(got), 32'(exp));
        b_accept();
    endtask

    task automatic ar_issue(input logic [4:0] a);
        bit hs;
        int n;
        hs = 0; n = 0;
        @(posedge clock); #1;
        s_axi_arvalid = 1'b1; s_axi_araddr = a;
        while (!hs && n < 50) begin
            @(negedge clock);
            hs = s_axi_arready;
            @(posedge clock); #1;
            n++;
        end
        s_axi_arvalid = 1'b0;
        if (!hs) fail_timeout("ar_handshake");
    endtask

    task automatic wait_rvalid();
        int n;
        n = 0;
        do begin @(negedge clock); n++; end while (!s_axi_rvalid && n < 50);
        if (!s_axi_rvalid) fail_timeout("rvalid");
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        logic [31:0] exp;
        exp = model_read(a);
        ar_issue(a);
        wait_rvalid();
        d = s_axi_rdata;
        check($sformatf("rdata_%h", a), d, exp);
        check("rresp", 32'(s_axi_rresp), 32'h0);
        s_axi_rready = 1'b1;
        @(posedge clock); #1;
        s_axi_rready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  br;
        logic [4:0]  wa [4];
        model_reset();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // reset state
        @(negedge clock);
        check("rst_awready", 32'(s_axi_awready), 32'h1);
        check("rst_wready",  32'(s_axi_wready),  32'h1);
        check("rst_arready", 32'(s_axi_arready), 32'h1);
        check("rst_bvalid",  32'(s_axi_bvalid),  32'h0);
        check("rst_rvalid",  32'(s_axi_rvalid),  32'h0);
        check("rst_rdata",   s_axi_rdata,        32'h0);
        axi_read(5'h1C, rd);
        check("id_lit", rd, 32'hADD0_0001);

        // basic write/read-back
        wa[0] = 5'h00; wa[1] = 5'h04; wa[2] = 5'h08; wa[3] = 5'h0C;
        for (int i = 0; i < 4; i++) axi_write(wa[i], 32'(i + 1), 4'hF, br);
        for (int i = 0; i < 4; i++) begin
            axi_read(wa[i], rd);
            check("readback_lit", rd, 32'(i + 1));
        end
        axi_read(5'h18, rd);
        check("wrcnt_lit4", rd, 32'd4);
        axi_read(5'h10, rd);
        check("sum_lit3", rd, 32'd3);

        // overflow sum / carry
        axi_write(5'h00, 32'hFFFF_FFFF, 4'hF, br);
        axi_write(5'h04, 32'h0000_0002, 4'hF, br);
        axi_read(5'h10, rd);
`ifdef AXIL_ADDER_SAT_EN
        check("sum_ovf_lit", rd, 32'hFFFF_FFFF);
`else
        check("sum_ovf_lit", rd, 32'h0000_0001);
`endif
        axi_read(5'h14, rd);
        check("carry_lit", rd, 32'h1);

        // read-only address write
        axi_write(5'h1C, 32'hDEAD_BEEF, 4'hF, br);
        check("slverr_lit", 32'(br), 32'h2);
        axi_read(5'h1C, rd);
        axi_read(5'h18, rd);
        check("wrcnt_lit6", rd, 32'd6);

        // byte strobes
        axi_write(5'h08, 32'h1122_3344, 4'hF, br);
        axi_write(5'h08, 32'hAABB_CCDD, 4'b0101, br);
        axi_read(5'h08, rd);
        check("strobe_lit", rd, 32'h11BB_33DD);

        // zero strobe still counts
        axi_write(5'h0C, 32'hFFFF_0000, 4'h0, br);
        axi_read(5'h0C, rd);
        check("zstrb_data_lit", rd, 32'd4);
        axi_read(5'h18, rd);
        check("wrcnt_lit9", rd, 32'd9);

        // W leads AW by 3 cycles; B held off while a second write buffers
        do_aw_w(5'h0C, 32'h3333_3333, 4'hF, 3);
        wait_bvalid();
        do_aw_w(5'h00, 32'h0000_00AA, 4'hF, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("hold_bvalid",  32'(s_axi_bvalid),  32'h1);
            check("hold_awready", 32'(s_axi_awready), 32'h0);
            check("hold_wready",  32'(s_axi_wready),  32'h0);
            check("hold_op_a",    op_a,               32'hFFFF_FFFF);
        end
        model_write(5'h0C, 32'h3333_3333, 4'hF, br);
        check("hold_bresp1", 32'(s_axi_bresp), 32'(br));
        b_accept();
        wait_bvalid();
        model_write(5'h00, 32'h0000_00AA, 4'hF, br);
        check("hold_bresp2", 32'(s_axi_bresp), 32'(br));
        b_accept();
        axi_read(5'h0C, rd);
        axi_read(5'h00, rd);
        check("second_write_lit", rd, 32'h0000_00AA);
        axi_read(5'h18, rd);
        check("wrcnt_lit11", rd, 32'd11);
        axi_read(5'h10, rd);

        // reset with B and R both pending
        do_aw_w(5'h04, 32'h0000_0055, 4'hF, 0);
        wait_bvalid();
        ar_issue(5'h08);
        wait_rvalid();
        check("pre_rst_bvalid", 32'(s_axi_bvalid), 32'h1);
        reset = 1'b1;
        model_reset();
        @(posedge clock); #1;
        check("mid_rst_bvalid",  32'(s_axi_bvalid),  32'h0);
        check("mid_rst_rvalid",  32'(s_axi_rvalid),  32'h0);
        check("mid_rst_awready", 32'(s_axi_awready), 32'h1);
        check("mid_rst_wready",  32'(s_axi_wready),  32'h1);
        check("mid_rst_arready", 32'(s_axi_arready), 32'h1);
        check("mid_rst_rdata",   s_axi_rdata,        32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            axi_read(wa[i], rd);
            check("post_rst_lit", rd, 32'h0);
        end
        axi_read(5'h18, rd);
        axi_write(5'h04, 32'h0000_0007, 4'hF, br);
        axi_read(5'h10, rd);
        check("post_rst_sum_lit", rd, 32'd7);

        repeat (3) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
